sub32_seq: RTL

- Multi-cycle two's-complement subtractor: computes diff = a − b one SLICE-bit slice per cycle, least significant slice first, with a registered borrow chain between slices.
- Complements the team's combinational sliced adders and reuses their carry-chained slice structure for the subtract direction.
- Valid/ready handshake on input and output; sits in datapaths that trade latency for one narrow slice subtractor.

---
 rtl/sub32_seq_pkg.sv | 27 ++
 rtl/sub32_seq_sub_slice.sv | 18 +
 rtl/sub32_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sub32_seq_pkg.sv
// Shared definitions for the sliced sequential subtractor: FSM encoding and
// slice-count helpers used at elaboration.
package sub32_seq_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } state_e;

   // Number of compute cycles per operation.
   function automatic int unsigned num_slices(input int unsigned width,
                                              input int unsigned slice);
      return width / slice;
   endfunction

   // Operand width must split into whole slices.
   function automatic bit slices_ok(input int unsigned width, input int unsigned slice);
      return (slice != 0) && (width != 0) && ((width % slice) == 0);
   endfunction

   // Index register width; at least one bit even for a single slice.
   function automatic int unsigned idx_width(input int unsigned nslices);
      return (nslices > 1) ? $clog2(nslices) : 1;
   endfunction

endpackage

// File: rtl/sub32_seq_sub_slice.sv
// Combinational SLICE-bit subtractor with borrow in/out:
// {bout, diff} = a - b - bin.
module sub_slice #(
   parameter int unsigned SLICE = 16
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             bin,
   output logic [SLICE-1:0] diff,
   output logic             bout
);

   // Widen by one bit so the wrap-around of the subtraction lands in bout.
   always_comb begin
      {bout, diff} = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bin};
   end

endmodule

// File: rtl/sub32_seq.sv
// Multi-cycle two's-complement subtractor. Operands are captured on accept and
// processed one SLICE-bit slice per cycle, least significant first, with the
// borrow carried between slices in a register.
module sub32_seq
   import sub32_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             overflow
);

   localparam int unsigned NSLICES = num_slices(WIDTH, SLICE);
   localparam int unsigned IdxW    = idx_width(NSLICES);

   if (!slices_ok(WIDTH, SLICE)) begin : gen_bad_cfg
      $error("sub32_seq: WIDTH must be a non-zero multiple of SLICE");
   end

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic [IdxW-1:0]    idx_q, idx_d;
   logic               chain_q, chain_d;
   logic               borrow_q, borrow_d;
   logic               overflow_q, overflow_d;

   logic [SLICE-1:0]   slice_a, slice_b, slice_diff;
   logic               slice_bout;
   logic               last_slice;

   // Select the current slice of the captured operands.
   always_comb begin
      slice_a    = a_q[idx_q*SLICE +: SLICE];
      slice_b    = b_q[idx_q*SLICE +: SLICE];
      last_slice = (idx_q == IdxW'(NSLICES - 1));
   end

   sub_slice #(
      .SLICE (SLICE)
   ) u_sub_slice (
      .a    (slice_a),
      .b    (slice_b),
      .bin  (chain_q),
      .diff (slice_diff),
      .bout (slice_bout)
   );

   // Next-state logic: handshake, slice sequencing and result flags.
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      diff_d     = diff_q;
      idx_d      = idx_q;
      chain_d    = chain_q;
      borrow_d   = borrow_q;
      overflow_d = overflow_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               chain_d = 1'b0;
               idx_d   = '0;
               state_d = StBusy;
            end
         end
         StBusy: begin
            diff_d[idx_q*SLICE +: SLICE] = slice_diff;
            chain_d = slice_bout;
            idx_d   = idx_q + 1'b1;
            if (last_slice) begin
               idx_d      = '0;
               borrow_d   = slice_bout;
               // Signed overflow: operand signs differ and result sign leaves a's sign.
               overflow_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                            (slice_diff[SLICE-1] != a_q[WIDTH-1]);
               state_d    = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         a_q        <= '0;
         b_q        <= '0;
         diff_q     <= '0;
         idx_q      <= '0;
         chain_q    <= 1'b0;
         borrow_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         diff_q     <= diff_d;
         idx_q      <= idx_d;
         chain_q    <= chain_d;
         borrow_q   <= borrow_d;
         overflow_q <= overflow_d;
      end
   end

   // Handshake outputs decode directly from the state.
   always_comb begin
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);
      diff      = diff_q;
      borrow    = borrow_q;
      overflow  = overflow_q;
   end

endmodule
